skew_stream_buffer: RTL
=======================

# skew_stream_buffer

Parametrised, flow-controlled skew/deskew buffer that sits between an operand memory and one edge of the systolic array (and, in deskew mode, between the array's output edge and the result writer). Each accepted input vector of HEIGHT lanes is delayed per lane so that lane i reaches the array one beat after lane i-1, or so that a skewed result wavefront is realigned. Unlike the fixed triangle delay, it supports backpressure, per-lane valid tracking, frame boundaries with automatic drain, and a runtime skew/deskew mode.

## Interface
- HEIGHT, 32, number of lanes (≥2)
- DATA_WIDTH, 16, bits per lane
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = skew, 1 = deskew; sampled only on the first accepted beat of a frame
- in_valid  in  1  input vector valid
- in_ready  out  1  buffer accepts a vector this cycle
- in_data  in  HEIGHT*DATA_WIDTH  lane i at bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]
- in_last  in  1  marks the final vector of a frame
- out_valid  out  1  OR of out_lane_valid
- out_ready  in  1  downstream accepts the output
- out_data  out  HEIGHT*DATA_WIDTH  skewed vector, same lane packing; invalid lanes drive 0
- out_lane_valid  out  HEIGHT  per-lane valid
- out_last  out  1  final output beat of the frame

## Operation
- Advance: adv = out_ready | ~out_valid. All delay lines, valid bits and last tag shift only when adv=1; otherwise everything holds.
- Lane delay, in advances: skew mode d(i) = i+1; deskew mode d(i) = HEIGHT-i. Every lane is registered (minimum delay 1).
- Each lane carries data plus a valid bit. A beat with in_valid=0 while adv=1 injects a bubble (data 0, valid 0).
- Last tag travels with the longest lane (lane HEIGHT-1 in skew, lane 0 in deskew); out_last = the tag at that lane's output.
- States: IDLE (nothing in flight), STREAM, DRAIN.
  - IDLE: in_ready=adv. On accept: latch mode, go to STREAM (or DRAIN if in_last).
  - STREAM: in_ready=adv. Accepting a beat with in_last=1 → DRAIN.
  - DRAIN: in_ready=0; lanes keep shifting bubbles in on each advance. Leave to IDLE on the cycle out_last is handshaked (out_valid & out_ready & out_last).
- Mode change during STREAM/DRAIN is ignored until IDLE.
- A single-beat frame (in_last on first beat) is legal: IDLE → DRAIN directly.
- Widths: drain counter not required; state and latched mode only. No arithmetic on data.

## Timing
- Reset values: out_data=0, out_lane_valid=0, out_valid=0, out_last=0, in_ready=0 during rst; state=IDLE, all lane registers and valid bits 0. in_ready=1 from the first cycle after rst deasserts.
- Latency with out_ready held 1: lane i of beat accepted at cycle t appears at cycle t+d(i).
- Frame of N beats, no stalls: out_last at cycle t0 + (N-1) + HEIGHT; in_ready low from t0+N until the cycle after out_last.
- Stall: out_ready=0 with out_valid=1 freezes outputs bit-exact; in_ready=0 in the same cycle.
- Reset mid-frame: in-flight data discarded, state IDLE, latched mode returns to 0.
- Outputs registered; in_ready is combinational from state, out_valid, out_ready.

## Configuration
- SKEW_DESKEW_EN defined: mode input honoured, deskew delays d(i)=HEIGHT-i available.
- Undefined: mode port present but ignored, always skew; last tag fixed on lane HEIGHT-1; deskew delay logic not generated.

## Structure
- Package skew_pkg: state enum (IDLE, STREAM, DRAIN), mode constants MODE_SKEW=0, MODE_DESKEW=1, lane-delay function d(i, mode).
- One sub-module lane_delay (parameters MAX_DEPTH, DATA_WIDTH; ports clk, rst, adv, depth select, data+valid in/out), instantiated per lane; lane i is built with depth max(i+1, HEIGHT-i) and taps the output selected by mode.

## Test plan
- HEIGHT=4, skew, out_ready=1, frame of 3 beats 0x0A0B0C0D… → lane 0 at +1, lane 3 at +4; out_last 6 cycles after first accept.
- Same frame, out_ready=0 for cycles 2–4 → outputs frozen, in_ready=0, full frame still delivered in order, out_last delayed by 3.
- in_valid gap between beats 1 and 2 → bubble lanes show out_lane_valid=0, data 0; skew alignment preserved.
- Deskew mode (SKEW_DESKEW_EN), input pre-skewed by 1 beat/lane → all 4 lanes valid together, one beat per cycle after HEIGHT.
- Single-beat frame with in_last=1 → IDLE→DRAIN, out_last exactly once, back to IDLE; mode toggled mid-frame ignored.
- rst asserted during DRAIN → all outputs 0 same cycle, in_ready=1 the cycle after release, next frame correct.

Source files
------------

// File: rtl/skew_pkg.sv
// Shared types and helpers for the skew/deskew stream buffer.
// SKEW_DESKEW_EN (when defined) enables the runtime deskew delay profile.
package skew_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

  // Number of advances between acceptance and appearance for a given lane.
  function automatic int lane_delay_of(input int lane, input int height, input logic mode);
    return (mode == MODE_DESKEW) ? (height - lane) : (lane + 1);
  endfunction

  function automatic int sel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// One lane of the skew buffer: a MAX_DEPTH-stage data+valid shift register
// that moves only on adv, with a selectable output tap (tap k = delay k+1).
module lane_delay #(
  parameter int MAX_DEPTH  = 1,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_W      = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic [SEL_W-1:0]      tap_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0]  valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (adv) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (tap_sel == SEL_W'(k)) begin
        out_data  = data_q[k];
        out_valid = valid_q[k];
      end
    end
  end

endmodule

// File: rtl/skew_stream_buffer.sv
// Flow-controlled skew/deskew buffer with frame tracking and automatic drain.
// Define SKEW_DESKEW_EN to honour the mode input (deskew delays HEIGHT-i).
module skew_stream_buffer
  import skew_pkg::*;
#(
  parameter int HEIGHT     = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [HEIGHT*DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [HEIGHT*DATA_WIDTH-1:0] out_data,
  output logic [HEIGHT-1:0]            out_lane_valid,
  output logic                         out_last,
  output logic [1:0]                   dbg_state
);

  // Handshake: a beat transfers on a port in any cycle where valid & ready are
  // both high; valid never depends on ready. Upstream ready is low in DRAIN and
  // whenever a held output is stalled (out_valid & ~out_ready).

  state_e state_q, state_d;
  logic   adv;
  logic   accept;
  logic   mode_eff;
  logic   last_hs;

  logic [HEIGHT-1:0]            lane_valid;
  logic [HEIGHT*DATA_WIDTH-1:0] lane_data;
  logic [HEIGHT-1:0]            last_q;

  assign adv     = out_ready | ~out_valid;
  assign accept  = in_valid & in_ready;
  assign last_hs = out_valid & out_ready & out_last;

`ifdef SKEW_DESKEW_EN
  logic mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_SKEW;
    end else if (state_q == IDLE && accept) begin
      mode_q <= mode;
    end
  end

  assign mode_eff = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = MODE_SKEW;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : STREAM;
      STREAM:  if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready       = ~rst & adv & (state_q != DRAIN);
    out_valid      = |lane_valid;
    out_lane_valid = lane_valid;
    out_data       = lane_data;
    out_last       = last_q[HEIGHT-1];
    dbg_state      = state_q;
  end

  // The frame-end tag rides alongside whichever lane has delay HEIGHT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (adv) begin
      last_q <= {last_q[HEIGHT-2:0], accept & in_last};
    end
  end

  for (genvar i = 0; i < HEIGHT; i++) begin : g_lane
`ifdef SKEW_DESKEW_EN
    localparam int MAXD = ((i + 1) > (HEIGHT - i)) ? (i + 1) : (HEIGHT - i);
`else
    localparam int MAXD = i + 1;
`endif
    localparam int SW = sel_width(MAXD);

    logic [SW-1:0]         tap_sel;
    logic [DATA_WIDTH-1:0] lane_in;

    assign tap_sel = SW'(lane_delay_of(i, HEIGHT, mode_eff) - 1);
    assign lane_in = accept ? in_data[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH] : '0;

    lane_delay #(
      .MAX_DEPTH  (MAXD),
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_W      (SW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .tap_sel   (tap_sel),
      .in_data   (lane_in),
      .in_valid  (accept),
      .out_data  (lane_data[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]),
      .out_valid (lane_valid[i])
    );
  end

endmodule
